// File: rtl/spram_arb_pkg.sv
// Shared definitions for the SPRAM port arbiter: power-state encoding,
// requester port indices and data-path widths.
package spram_arb_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        SLEEP  = 2'd1,
        WAKE   = 2'd2
    } pwr_state_e;

    localparam logic PORT_CPU    = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

endpackage

// File: rtl/spram_power_seq.sv
// SPRAM power sequencer: puts the RAM to SLEEP after a run of idle cycles
// and holds off access for a fixed number of cycles after waking.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   any_valid    some requester is asking for the memory this cycle
//   access_en    memory may be granted this cycle (ACTIVE and not in reset)
//   mem_sleep    SPRAM SLEEP pin
module spram_power_seq
    import spram_arb_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = 1024,
    parameter int unsigned WAKE_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic any_valid,
    output logic access_en,
    output logic mem_sleep
);

    localparam int unsigned IDLE_W = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
    localparam int unsigned WAKE_W = $clog2(WAKE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_CYCLES);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

    pwr_state_e        state, state_next;
    logic [IDLE_W-1:0] idle_cnt, idle_next;
    logic [WAKE_W-1:0] wake_cnt, wake_next;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACTIVE;
            idle_cnt <= '0;
            wake_cnt <= '0;
        end else begin
            state    <= state_next;
            idle_cnt <= idle_next;
            wake_cnt <= wake_next;
        end
    end

    // Next state; counters clear whenever they are not actively counting
    always_comb begin
        state_next = state;
        idle_next  = '0;
        wake_next  = '0;
        case (state)
            ACTIVE: begin
                // Sleep only in a cycle that is itself idle, so no grant can
                // be issued in the cycle before SLEEP
                if (!any_valid) begin
                    if ((IDLE_CYCLES != 0) && (idle_cnt == IDLE_MAX)) begin
                        state_next = SLEEP;
                    end else if (idle_cnt != IDLE_MAX) begin
                        idle_next = idle_cnt + IDLE_W'(1);
                    end else begin
                        idle_next = idle_cnt;
                    end
                end
            end
            SLEEP: begin
                if (any_valid) begin
                    state_next = WAKE;
                end
            end
            WAKE: begin
                // Wake-up runs to completion even if the request goes away
                if (wake_cnt == WAKE_LAST) begin
                    state_next = ACTIVE;
                end else begin
                    wake_next = wake_cnt + WAKE_W'(1);
                end
            end
            default: state_next = ACTIVE;
        endcase
    end

    // Reset forces both outputs low in the reset cycle itself
    assign access_en = (state == ACTIVE) && !rst;
    assign mem_sleep = (state == SLEEP) && !rst;

endmodule

// File: rtl/spram_port_arbiter.sv
// Two-port arbiter in front of a single-port 32-bit SPRAM.
// Port 0 (CPU) has priority; port 1 (loader) wins once it has been denied
// STARVE_LIMIT cycles in a row. Reads return one cycle after acceptance.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   p0_* / p1_*              requester ports: valid/ready handshake with
//                            write, wmask, wdata, addr; rvalid/rdata return
//   mem_write/wmask/wdata/addr, mem_rdata, mem_sleep   SPRAM wrapper pins
module spram_port_arbiter
    import spram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 14,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned IDLE_CYCLES  = 1024,
    parameter int unsigned WAKE_CYCLES  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_valid,
    input  logic                  p0_write,
    input  logic [MASK_WIDTH-1:0] p0_wmask,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    output logic                  p0_ready,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_valid,
    input  logic                  p1_write,
    input  logic [MASK_WIDTH-1:0] p1_wmask,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    output logic                  p1_ready,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  mem_write,
    output logic [MASK_WIDTH-1:0] mem_wmask,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_sleep
);

    localparam int unsigned STARVE_W = 4;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic                access_en;
    logic                any_valid;
    logic                grant0;
    logic                grant1;
    logic [STARVE_W-1:0] starve_cnt;
    logic                rd_valid;
    logic                rd_port;

    assign any_valid = p0_valid | p1_valid;

    spram_power_seq #(
        .IDLE_CYCLES(IDLE_CYCLES),
        .WAKE_CYCLES(WAKE_CYCLES)
    ) u_power_seq (
        .clk      (clk),
        .rst      (rst),
        .any_valid(any_valid),
        .access_en(access_en),
        .mem_sleep(mem_sleep)
    );

    // Port 1 wins when port 0 is idle or once it has starved long enough
    assign grant1   = access_en & p1_valid & (~p0_valid | (starve_cnt == STARVE_MAX));
    assign grant0   = access_en & p0_valid & ~grant1;
    assign p0_ready = grant0;
    assign p1_ready = grant1;

    // Memory pins follow port 0 unless port 1 holds the grant
    assign mem_write = (grant0 & p0_write) | (grant1 & p1_write);
    assign mem_wmask = grant1 ? p1_wmask : p0_wmask;
    assign mem_wdata = grant1 ? p1_wdata : p0_wdata;
    assign mem_addr  = grant1 ? p1_addr  : p0_addr;

    // Starvation counter and read-return tag
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            rd_valid   <= 1'b0;
            rd_port    <= PORT_CPU;
        end else begin
            if (grant1) begin
                starve_cnt <= '0;
            end else if (p1_valid && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
            rd_valid <= (grant0 & ~p0_write) | (grant1 & ~p1_write);
            rd_port  <= grant1 ? PORT_LOADER : PORT_CPU;
        end
    end

    // A read in flight when reset arrives is dropped immediately
    assign p0_rvalid = rd_valid & (rd_port == PORT_CPU) & ~rst;
    assign p1_rvalid = rd_valid & (rd_port == PORT_LOADER) & ~rst;
    assign p0_rdata  = mem_rdata;
    assign p1_rdata  = mem_rdata;

endmodule

// File: tb/tb_spram_port_arbiter.sv
// Bench for spram_port_arbiter: SPRAM environment model, directed scenarios
// with literal expectations, then randomized traffic checked every cycle
// against a transaction-level reference model.
module tb_spram_port_arbiter;

    localparam int unsigned AW     = 14;
    localparam int unsigned STARVE = 4;
    localparam int unsigned IDLE   = 8;
    localparam int unsigned WAKE   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_valid, p0_write, p1_valid, p1_write;
    logic [3:0]    p0_wmask, p1_wmask;
    logic [31:0]   p0_wdata, p1_wdata;
    logic [AW-1:0] p0_addr, p1_addr;
    logic          p0_ready, p0_rvalid, p1_ready, p1_rvalid;
    logic [31:0]   p0_rdata, p1_rdata;
    logic          mem_write, mem_sleep;
    logic [3:0]    mem_wmask;
    logic [31:0]   mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata = 32'h0;

    int tot  = 0;
    int pass = 0;

    spram_port_arbiter #(
        .ADDR_WIDTH(AW), .STARVE_LIMIT(STARVE), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_write(p0_write), .p0_wmask(p0_wmask), .p0_wdata(p0_wdata),
        .p0_addr(p0_addr), .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_write(p1_write), .p1_wmask(p1_wmask), .p1_wdata(p1_wdata),
        .p1_addr(p1_addr), .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_write(mem_write), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_sleep(mem_sleep)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act === exp) pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- SPRAM environment ----------------
    logic [31:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (!mem_sleep) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
            mem_rdata <= ram[mem_addr];
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] shadow [int];
    bit          m_asleep;
    int          m_wake_left, m_idle_run, m_starve;
    bit          m_pend, m_pend_port;
    logic [31:0] m_pend_data;
    bit          e_act, e_g0, e_g1, e_wr;
    logic [AW-1:0] e_addr;
    logic [31:0] e_old, e_new;

    function automatic logic [31:0] shadow_rd(input int a);
        return shadow.exists(a) ? shadow[a] : 32'h0;
    endfunction

    always @(negedge clk) begin
        e_act = !rst && !m_asleep && (m_wake_left == 0);
        e_g1  = e_act && p1_valid && (!p0_valid || m_starve >= int'(STARVE));
        e_g0  = e_act && p0_valid && !e_g1;
        e_wr  = e_g1 ? p1_write : (e_g0 ? p0_write : 1'b0);
        e_addr = e_g1 ? p1_addr : p0_addr;
        check("p0_ready",  32'(p0_ready),  32'(e_g0));
        check("p1_ready",  32'(p1_ready),  32'(e_g1));
        check("mem_write", 32'(mem_write), 32'(e_wr));
        check("mem_addr",  32'(mem_addr),  32'(e_addr));
        check("mem_wmask", 32'(mem_wmask), 32'(e_g1 ? p1_wmask : p0_wmask));
        check("mem_wdata", mem_wdata,      e_g1 ? p1_wdata : p0_wdata);
        check("mem_sleep", 32'(mem_sleep), 32'(!rst && m_asleep));
        check("p0_rvalid", 32'(p0_rvalid), 32'(!rst && m_pend && !m_pend_port));
        check("p1_rvalid", 32'(p1_rvalid), 32'(!rst && m_pend && m_pend_port));
        if (!rst && m_pend && !m_pend_port) check("p0_rdata", p0_rdata, m_pend_data);
        if (!rst && m_pend && m_pend_port)  check("p1_rdata", p1_rdata, m_pend_data);

        if (rst) begin
            m_asleep = 0; m_wake_left = 0; m_idle_run = 0; m_starve = 0; m_pend = 0;
        end else begin
            m_pend = 0;
            if (e_g0 || e_g1) begin
                e_old = shadow_rd(int'(e_addr));
                if (e_wr) begin
                    e_new = e_old;
                    for (int b = 0; b < 4; b++)
                        if ((e_g1 ? p1_wmask[b] : p0_wmask[b]))
                            e_new[b*8 +: 8] = e_g1 ? p1_wdata[b*8 +: 8] : p0_wdata[b*8 +: 8];
                    shadow[int'(e_addr)] = e_new;
                end else begin
                    m_pend = 1; m_pend_port = e_g1; m_pend_data = e_old;
                end
            end
            if (e_g1) m_starve = 0;
            else if (p1_valid && m_starve < int'(STARVE)) m_starve++;
            if (m_asleep) begin
                if (p0_valid || p1_valid) begin m_asleep = 0; m_wake_left = WAKE; end
            end else if (m_wake_left > 0) begin
                m_wake_left--;
            end else if (p0_valid || p1_valid) begin
                m_idle_run = 0;
            end else begin
                m_idle_run++;
                if (IDLE != 0 && m_idle_run > int'(IDLE)) begin m_asleep = 1; m_idle_run = 0; end
            end
        end
    end

    // ---------------- directed helpers ----------------
    function automatic logic rdy(input int port);
        return (port != 0) ? p1_ready : p0_ready;
    endfunction

    task automatic drive(input int port, input logic wr, input logic [3:0] m,
                         input logic [31:0] d, input logic [AW-1:0] a, output int stalls);
        if (port == 0) begin p0_valid = 1; p0_write = wr; p0_wmask = m; p0_wdata = d; p0_addr = a; end
        else           begin p1_valid = 1; p1_write = wr; p1_wmask = m; p1_wdata = d; p1_addr = a; end
        stalls = 0;
        @(negedge clk);
        while (!rdy(port) && stalls < 50) begin stalls++; @(negedge clk); end
        if (!rdy(port)) check("ready timeout", 32'(rdy(port)), 32'h1);
        @(posedge clk); #1;
        if (port == 0) p0_valid = 0; else p1_valid = 0;
    endtask

    task automatic read_chk(input string name, input int port, input logic [AW-1:0] a,
                            input logic [31:0] exp, output int stalls);
        drive(port, 1'b0, 4'h0, 32'h0, a, stalls);
        @(negedge clk);
        check({name, " rvalid"}, 32'((port != 0) ? p1_rvalid : p0_rvalid), 32'h1);
        check({name, " rdata"}, (port != 0) ? p1_rdata : p0_rdata, exp);
    endtask

    int          st, j, quiet;
    logic [9:0]  pat;
    bit          acc0, acc1;

    initial begin
        rst = 1;
        p0_valid = 0; p0_write = 0; p0_wmask = 0; p0_wdata = 0; p0_addr = 0;
        p1_valid = 0; p1_write = 0; p1_wmask = 0; p1_wdata = 0; p1_addr = 0;
        for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
        ram[16] = 32'hCAFEF00D;
        shadow[16] = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // Sleep entry after reset with no traffic
        j = 0;
        @(negedge clk);
        while (!mem_sleep && j < 40) begin j++; @(negedge clk); end
        check("sleep entry cycle", 32'(j), 32'd9);

        // Loader read wakes the RAM: 1 sleep + 3 wake stall cycles
        @(posedge clk); #1;
        read_chk("wake read", 1, 14'h0010, 32'hCAFEF00D, st);
        check("wake stalls", 32'(st), 32'd4);

        // Full-word write then read back
        drive(0, 1'b1, 4'hF, 32'hDEADBEEF, 14'h0004, st);
        read_chk("p0 rd 4", 0, 14'h0004, 32'hDEADBEEF, st);
        check("p1_rvalid quiet", 32'(p1_rvalid), 32'h0);

        // Byte-masked write
        drive(0, 1'b1, 4'hF, 32'h11223344, 14'h0008, st);
        drive(0, 1'b1, 4'h1, 32'h000000AA, 14'h0008, st);
        read_chk("p0 rd 8", 0, 14'h0008, 32'h112233AA, st);

        // Both ports valid continuously: starvation pattern
        @(posedge clk); #1;
        p0_valid = 1; p0_write = 0; p0_addr = 14'h0004;
        p1_valid = 1; p1_write = 0; p1_addr = 14'h0008;
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pat[i] = p1_ready;
            check("single grant", 32'(p0_ready ^ p1_ready), 32'h1);
        end
        check("grant pattern", 32'(pat), 32'h210);
        @(posedge clk); #1;
        p0_valid = 0; p1_valid = 0;
        @(posedge clk); #1;

        // p1 read then p0 read next cycle: no cross-routing
        p1_valid = 1; p1_write = 0; p1_addr = 14'h0004;
        @(negedge clk);
        check("b2b p1_ready", 32'(p1_ready), 32'h1);
        @(posedge clk); #1;
        p1_valid = 0; p0_valid = 1; p0_write = 0; p0_addr = 14'h0008;
        @(negedge clk);
        check("b2b p0_ready", 32'(p0_ready), 32'h1);
        check("b2b p1_rvalid", 32'(p1_rvalid), 32'h1);
        check("b2b p1_rdata", p1_rdata, 32'hDEADBEEF);
        check("b2b p0_rvalid early", 32'(p0_rvalid), 32'h0);
        @(posedge clk); #1;
        p0_valid = 0;
        @(negedge clk);
        check("b2b p0_rvalid", 32'(p0_rvalid), 32'h1);
        check("b2b p0_rdata", p0_rdata, 32'h112233AA);
        check("b2b p1_rvalid late", 32'(p1_rvalid), 32'h0);

        // Reset with a read in flight
        @(posedge clk); #1;
        p0_valid = 1; p0_write = 0; p0_addr = 14'h0004;
        @(negedge clk);
        check("inflight accept", 32'(p0_ready), 32'h1);
        @(posedge clk); #1;
        p0_valid = 0; rst = 1;
        @(negedge clk);
        check("rst drops rvalid", 32'(p0_rvalid), 32'h0);
        check("rst mem_write", 32'(mem_write), 32'h0);
        check("rst mem_sleep", 32'(mem_sleep), 32'h0);
        @(posedge clk); #1;
        rst = 0;
        read_chk("post-rst rd", 0, 14'h0008, 32'h112233AA, st);
        check("post-rst stalls", 32'(st), 32'd0);

        // Reset while asleep releases SLEEP in the reset cycle
        j = 0;
        @(negedge clk);
        while (!mem_sleep && j < 40) begin j++; @(negedge clk); end
        check("sleep reached", 32'(mem_sleep), 32'h1);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        check("rst in sleep", 32'(mem_sleep), 32'h0);
        @(posedge clk); #1;
        rst = 0;

        // Randomized traffic
        quiet = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            acc0 = p0_valid && p0_ready;
            acc1 = p1_valid && p1_ready;
            @(posedge clk); #1;
            if (rst) rst = 0;
            else if ($urandom_range(0, 699) == 0) rst = 1;
            if (quiet > 0) quiet--;
            else if ($urandom_range(0, 39) == 0) quiet = $urandom_range(6, 20);
            if (!p0_valid || acc0) begin
                if (quiet == 0 && $urandom_range(0, 99) < 60) begin
                    p0_valid = 1; p0_write = 1'($urandom_range(0, 1)); p0_wmask = 4'($urandom);
                    p0_wdata = $urandom; p0_addr = AW'($urandom_range(0, 31));
                end else p0_valid = 0;
            end
            if (!p1_valid || acc1) begin
                if (quiet == 0 && $urandom_range(0, 99) < 40) begin
                    p1_valid = 1; p1_write = 1'($urandom_range(0, 1)); p1_wmask = 4'($urandom);
                    p1_wdata = $urandom; p1_addr = AW'($urandom_range(0, 31));
                end else p1_valid = 0;
            end
        end
        @(posedge clk); #1;
        p0_valid = 0; p1_valid = 0; rst = 0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", pass, tot);
        $finish;
    end

endmodule
